phy_link_monitor: RTL and testbench
===================================

Name: phy_link_monitor

Overview:
- Autonomous MDIO management master; periodically reads the Ethernet PHY's specific-status register.
- Decodes link state and resolved speed into the TSE tx clock-select controls (eth_mode, ena_10) and a link_up flag.
- Sits between the PHY MDIO pins and the tx_clk mux/DDIO clock-out stage.
- Speed selection follows the PHY, independent of software.

Parameters:
- MDC_HALF, 20: clk cycles per MDC half-period; 100 MHz clk gives 2.5 MHz MDC. Minimum 2.
- POLL_CYCLES, 1000000: clk cycles from the end of one frame to the start of the next.
- PHY_ADDR, 5'd0: PHY address placed in the frame.
- STAT_REG, 5'd17: PHY-specific status register address.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  polling enable; low = no new frames start.
- mdc  out  1  MDIO clock.
- mdio_in  in  1  MDIO pad input.
- mdio_out  out  1  MDIO output data.
- mdio_oen  out  1  output disable; 1 = pad tri-stated.
- link_up  out  1  PHY reports link up.
- eth_mode  out  1  1 = 1000 Mb.
- ena_10  out  1  1 = 10 Mb. Both 0 = 100 Mb.
- status_valid  out  1  1-clk pulse after a successful read.
- link_change  out  1  1-clk pulse when {link_up, eth_mode, ena_10} changes.
- ack_err  out  1  1-clk pulse when the PHY did not drive TA low.
- phy_status  out  16  last successfully read register value.

Behaviour:
- Reset values:
  - mdc=0, mdio_out=1, mdio_oen=1.
  - link_up=0, eth_mode=0, ena_10=0 (100 Mb default).
  - All pulse outputs 0, phy_status=16'h0000.
  - State IDLE, poll counter=0.
- Async reset mid-frame: outputs return to reset values immediately; the frame is abandoned.
- MDC generation:
  - Divider counts 0..MDC_HALF-1; at wrap, mdc toggles.
  - mdc toggles continuously, including in IDLE.
  - Rising-edge event = wrap while mdc=0; falling-edge event = wrap while mdc=1.
- Output timing:
  - mdio_out/mdio_oen change only on falling-edge events.
  - mdio_in is sampled only on rising-edge events.
- State machine (each bit = one MDC period):
  - IDLE: poll counter decrements to 0, then reloads POLL_CYCLES on frame end. If en=1 and counter=0, go to PRE at the next falling-edge event. The first frame starts on the first falling edge after reset release.
  - PRE: 32 bits of 1, oen=0.
  - CMD: 14 bits MSB first: ST=01, OP=10 (read), PHY_ADDR, STAT_REG.
  - TA: oen=1 for 2 bits. Sample mdio_in on the rising edge of the second TA bit; a value of 1 sets a no-ack flag.
  - DATA: 16 bits sampled MSB first into a shift register; oen stays 1.
  - DONE: lasts 1 clk. Set mdio_out=1 (oen stays 1), reload the poll counter, update outputs, return to IDLE.
- Total frame: 64 MDC periods plus DONE.
- en deassert mid-frame: the frame completes normally; no new frame starts.
- DONE with no-ack:
  - ack_err=1 for 1 clk.
  - link_up forced 0; phy_status, eth_mode, ena_10 held; status_valid not pulsed.
- DONE with ack:
  - phy_status <= data; status_valid=1 for 1 clk.
  - If data[11]=1 (resolved):
    - link_up <= data[10].
    - data[15:14]=10: eth_mode=1, ena_10=0.
    - data[15:14]=01: eth_mode=0, ena_10=0.
    - data[15:14]=00: eth_mode=0, ena_10=1.
    - data[15:14]=11 (reserved): speed outputs held.
  - If data[11]=0: link_up <= 0, speed outputs held.
- link_change pulses in the same cycle the changed outputs become visible. It never pulses on reset.
- eth_mode and ena_10 are never both 1.

Test Plan (MDC_HALF=2, POLL_CYCLES=400, PHY_ADDR=5'd0, STAT_REG=5'd17):
- Reset release with en=1 → first falling edge starts the frame. Bench decodes 32 ones, then 0110_00000_10001. mdio_oen=1 during TA and DATA. MDC period is 4 clk.
- PHY model returns 16'hAC00 (speed 10, resolved, link) → link_up=1, eth_mode=1, ena_10=0. status_valid and link_change each pulse once. phy_status=16'hAC00.
- Next poll returns 16'h0C00 → ena_10=1, eth_mode=0, link_change pulses. A further poll returning 16'h0C00 → status_valid pulses, link_change stays 0. Gap between frames is 400 clk.
- PHY absent (mdio_in held 1) after a 1000 Mb link → ack_err pulses, link_up=0, eth_mode stays 1, link_change pulses, phy_status unchanged.
- Return 16'hC800 (reserved speed, resolved, no link) → link_up=0, speed outputs held. Return 16'h8400 (unresolved) → link_up=0, speed outputs held.
- en dropped mid-DATA → frame completes with status_valid, then no new frame for ≥2000 clk. Assert reset mid-PRE → mdio_oen=1 and mdc=0 in the same cycle; a fresh frame starts after release.

Source files
------------

// File: rtl/phy_link_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : phy_link_monitor                                           |
// | Description : Autonomous MDIO management master. Periodically reads the  |
// |               PHY-specific status register and turns the resolved link / |
// |               speed into the TSE tx clock-select controls.               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk          in   system clock                                         |
// |   reset        in   asynchronous active-high reset                       |
// |   en           in   polling enable (low = no new frame starts)           |
// |   mdc          out  MDIO clock, free running at clk / (2*MDC_HALF)       |
// |   mdio_in      in   MDIO pad input                                       |
// |   mdio_out     out  MDIO output data                                     |
// |   mdio_oen     out  output disable, 1 = pad tri-stated                   |
// |   link_up      out  PHY reports link up                                  |
// |   eth_mode     out  1 = 1000 Mb                                          |
// |   ena_10       out  1 = 10 Mb (both 0 = 100 Mb)                          |
// |   status_valid out  1-clk pulse after an acknowledged read               |
// |   link_change  out  1-clk pulse when {link_up,eth_mode,ena_10} changes   |
// |   ack_err      out  1-clk pulse when the PHY left TA high                |
// |   phy_status   out  last successfully read register value               |
// +--------------------------------------------------------------------------+
module phy_link_monitor #(
  parameter int unsigned MDC_HALF    = 20,
  parameter int unsigned POLL_CYCLES = 1000000,
  parameter logic [4:0]  PHY_ADDR    = 5'd0,
  parameter logic [4:0]  STAT_REG    = 5'd17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  output logic        link_up,
  output logic        eth_mode,
  output logic        ena_10,
  output logic        status_valid,
  output logic        link_change,
  output logic        ack_err,
  output logic [15:0] phy_status
);

  localparam int unsigned DIV_W  = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
  localparam int unsigned POLL_W = (POLL_CYCLES > 0) ? $clog2(POLL_CYCLES + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(MDC_HALF - 1);
  localparam logic [POLL_W-1:0] POLL_RELOAD = POLL_W'(POLL_CYCLES);

  // Clause-22 read header after the preamble: ST=01, OP=10, PHYAD, REGAD.
  localparam logic [13:0] CMD_WORD = {2'b01, 2'b10, PHY_ADDR, STAT_REG};

  // Last bit index of each serial phase (one bit = one MDC period).
  localparam logic [4:0] PRE_LAST  = 5'd31;
  localparam logic [4:0] CMD_LAST  = 5'd13;
  localparam logic [4:0] TA_LAST   = 5'd1;
  localparam logic [4:0] DATA_LAST = 5'd15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_CMD  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // MDC divider. mdc runs continuously; the wrap of the divider is the only
  // place mdc changes, so "wrap while low" is the rising edge and "wrap while
  // high" is the falling edge, both known one clk ahead of the pin.
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic             rise_ev;
  logic             fall_ev;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign rise_ev  = div_wrap & ~mdc;
  assign fall_ev  = div_wrap &  mdc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      mdc     <= ~mdc;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame engine state
  // --------------------------------------------------------------------------
  state_t            state;
  logic [4:0]        bit_cnt;
  logic [13:0]       tx_shift;
  logic [15:0]       rx_shift;
  logic              no_ack;
  logic [POLL_W-1:0] poll_cnt;

  // --------------------------------------------------------------------------
  // Decode of the register just read into the next clock-select outputs.
  // A missing ack and an unresolved link both drop link_up but keep the last
  // good speed so the tx clock mux does not glitch between rates while the
  // link is down. The reserved speed code also keeps the last speed.
  // --------------------------------------------------------------------------
  logic next_link;
  logic next_eth;
  logic next_ena10;
  logic next_change;

  always_comb begin
    next_link  = 1'b0;
    next_eth   = eth_mode;
    next_ena10 = ena_10;
    if (!no_ack && rx_shift[11]) begin
      next_link = rx_shift[10];
      case (rx_shift[15:14])
        2'b10: begin
          next_eth   = 1'b1;
          next_ena10 = 1'b0;
        end
        2'b01: begin
          next_eth   = 1'b0;
          next_ena10 = 1'b0;
        end
        2'b00: begin
          next_eth   = 1'b0;
          next_ena10 = 1'b1;
        end
        default: begin
          next_eth   = eth_mode;
          next_ena10 = ena_10;
        end
      endcase
    end
  end

  assign next_change = ({next_link, next_eth, next_ena10} != {link_up, eth_mode, ena_10});

  // --------------------------------------------------------------------------
  // Frame state machine with registered outputs. The master launches each bit
  // on an MDC falling edge and samples the PHY on the following rising edge,
  // so each branch acting on fall_ev drives the *next* bit of the frame.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      bit_cnt      <= 5'd0;
      tx_shift     <= 14'd0;
      rx_shift     <= 16'd0;
      no_ack       <= 1'b0;
      poll_cnt     <= '0;
      mdio_out     <= 1'b1;
      mdio_oen     <= 1'b1;
      link_up      <= 1'b0;
      eth_mode     <= 1'b0;
      ena_10       <= 1'b0;
      status_valid <= 1'b0;
      link_change  <= 1'b0;
      ack_err      <= 1'b0;
      phy_status   <= 16'h0000;
    end else begin
      status_valid <= 1'b0;
      link_change  <= 1'b0;
      ack_err      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (poll_cnt != '0) begin
            poll_cnt <= poll_cnt - 1'b1;
          end
          if (fall_ev && en && (poll_cnt == '0)) begin
            state    <= S_PRE;
            bit_cnt  <= 5'd0;
            no_ack   <= 1'b0;
            mdio_out <= 1'b1;
            mdio_oen <= 1'b0;
          end
        end

        S_PRE: begin
          if (fall_ev) begin
            if (bit_cnt == PRE_LAST) begin
              state    <= S_CMD;
              bit_cnt  <= 5'd0;
              mdio_out <= CMD_WORD[13];
              tx_shift <= {CMD_WORD[12:0], 1'b0};
            end else begin
              bit_cnt  <= bit_cnt + 5'd1;
              mdio_out <= 1'b1;
            end
          end
        end

        S_CMD: begin
          if (fall_ev) begin
            if (bit_cnt == CMD_LAST) begin
              // Release the pad for turnaround; the PHY owns the line now.
              state    <= S_TA;
              bit_cnt  <= 5'd0;
              mdio_out <= 1'b1;
              mdio_oen <= 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + 5'd1;
              mdio_out <= tx_shift[13];
              tx_shift <= {tx_shift[12:0], 1'b0};
            end
          end
        end

        S_TA: begin
          // A present PHY pulls the second turnaround bit low.
          if (rise_ev && (bit_cnt == TA_LAST)) begin
            no_ack <= mdio_in;
          end
          if (fall_ev) begin
            if (bit_cnt == TA_LAST) begin
              state   <= S_DATA;
              bit_cnt <= 5'd0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        S_DATA: begin
          if (rise_ev) begin
            rx_shift <= {rx_shift[14:0], mdio_in};
          end
          if (fall_ev) begin
            if (bit_cnt == DATA_LAST) begin
              state   <= S_DONE;
              bit_cnt <= 5'd0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        S_DONE: begin
          state       <= S_IDLE;
          mdio_out    <= 1'b1;
          mdio_oen    <= 1'b1;
          poll_cnt    <= POLL_RELOAD;
          link_up     <= next_link;
          eth_mode    <= next_eth;
          ena_10      <= next_ena10;
          link_change <= next_change;
          if (no_ack) begin
            ack_err <= 1'b1;
          end else begin
            status_valid <= 1'b1;
            phy_status   <= rx_shift;
          end
        end

        default: begin
          state    <= S_IDLE;
          mdio_out <= 1'b1;
          mdio_oen <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phy_link_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_phy_link_monitor                                        |
// | Description : Self-checking bench for phy_link_monitor. A PHY model      |
// |               decodes each frame and answers it; an outcome model keeps  |
// |               the expected link/speed state and is compared every clk.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_phy_link_monitor;

  localparam int MDC_HALF = 2;
  localparam int POLL     = 400;
  localparam logic [13:0] CMD_EXP = 14'b01_10_00000_10001;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oen;
  logic        link_up;
  logic        eth_mode;
  logic        ena_10;
  logic        status_valid;
  logic        link_change;
  logic        ack_err;
  logic [15:0] phy_status;

  always #5 clk = ~clk;

  phy_link_monitor #(
    .MDC_HALF   (MDC_HALF),
    .POLL_CYCLES(POLL),
    .PHY_ADDR   (5'd0),
    .STAT_REG   (5'd17)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .mdc         (mdc),
    .mdio_in     (mdio_in),
    .mdio_out    (mdio_out),
    .mdio_oen    (mdio_oen),
    .link_up     (link_up),
    .eth_mode    (eth_mode),
    .ena_10      (ena_10),
    .status_valid(status_valid),
    .link_change (link_change),
    .ack_err     (ack_err),
    .phy_status  (phy_status)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- outcome model ----------------
  // Link state kept as link flag + speed in Mb/s; outputs derived from it.
  bit          pending = 1'b0;
  bit          pend_present;
  logic [15:0] pend_data;
  bit          exp_link;
  int          exp_speed;
  logic [15:0] exp_status;
  int          sv_cnt = 0;
  int          ae_cnt = 0;
  int          lc_cnt = 0;
  int          last_done_cyc = 0;

  always @(negedge clk) begin : compare
    bit new_link;
    int new_speed;
    bit exp_sv;
    bit exp_ae;
    bit exp_lc;
    if (reset) begin
      exp_link   = 1'b0;
      exp_speed  = 100;
      exp_status = 16'h0000;
      pending    = 1'b0;
    end else begin
      exp_sv = 1'b0;
      exp_ae = 1'b0;
      exp_lc = 1'b0;
      if (pending && (status_valid || ack_err)) begin
        new_link  = 1'b0;
        new_speed = exp_speed;
        if (pend_present) begin
          exp_sv     = 1'b1;
          exp_status = pend_data;
          if (pend_data[11]) begin
            new_link = pend_data[10];
            case (pend_data[15:14])
              2'b10:   new_speed = 1000;
              2'b01:   new_speed = 100;
              2'b00:   new_speed = 10;
              default: new_speed = exp_speed;
            endcase
          end
        end else begin
          exp_ae = 1'b1;
        end
        exp_lc        = (new_link != exp_link) || (new_speed != exp_speed);
        exp_link      = new_link;
        exp_speed     = new_speed;
        pending       = 1'b0;
        last_done_cyc = cyc;
      end
      sv_cnt += int'(status_valid);
      ae_cnt += int'(ack_err);
      lc_cnt += int'(link_change);
      check("cycle_outputs",
            {10'd0, status_valid, ack_err, link_change, link_up, eth_mode, ena_10, phy_status},
            {10'd0, exp_sv, exp_ae, exp_lc, exp_link, (exp_speed == 1000), (exp_speed == 10), exp_status});
    end
  end

  // ---------------- PHY model ----------------
  task automatic wait_start(output int start_cyc, output bit ok);
    ok = 1'b0;
    start_cyc = 0;
    for (int i = 0; i < POLL + 200; i++) begin
      @(negedge clk);
      if (mdio_oen === 1'b0) begin
        ok = 1'b1;
        start_cyc = cyc;
        break;
      end
    end
    check("frame_start_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic serve_frame(input logic [15:0] resp, input bit present,
                             input bit drop_en, input bit chk_gap);
    int          st;
    int          gap;
    bit          ok;
    bit          pre_ok;
    bit          oen_ok;
    logic [13:0] cmd;
    wait_start(st, ok);
    if (!ok) return;
    if (chk_gap) begin
      gap = st - last_done_cyc;
      tests++;
      if (gap < POLL || gap > POLL + 4 * MDC_HALF) begin
        fails++;
        $display("FAIL poll_gap: got %0d clk, required %0d..%0d", gap, POLL, POLL + 4 * MDC_HALF);
      end
    end
    pre_ok = 1'b1;
    oen_ok = 1'b1;
    cmd    = '0;
    for (int b = 0; b < 64; b++) begin
      @(posedge mdc);
      #1;
      if (b < 32) begin
        if (mdio_oen !== 1'b0 || mdio_out !== 1'b1) pre_ok = 1'b0;
      end else if (b < 46) begin
        if (mdio_oen !== 1'b0) oen_ok = 1'b0;
        cmd = {cmd[12:0], mdio_out};
      end else begin
        if (mdio_oen !== 1'b1) oen_ok = 1'b0;
      end
      // Present the PHY's value for the next bit well before its rising edge.
      if (b + 1 == 47)                    mdio_in = present ? 1'b0 : 1'b1;
      else if (b + 1 >= 48 && b + 1 < 64) mdio_in = present ? resp[63 - (b + 1)] : 1'b1;
      else                                mdio_in = 1'b1;
      if (drop_en && b == 52) en = 1'b0;
    end
    check("preamble_32_ones", {31'd0, pre_ok}, 32'd1);
    check("cmd_bits", {18'd0, cmd}, {18'd0, CMD_EXP});
    check("oen_ta_data", {31'd0, oen_ok}, 32'd1);
    pend_data    = resp;
    pend_present = present;
    pending      = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (!pending) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_result_seen", {31'd0, ok}, 32'd1);
    pending = 1'b0;
  endtask

  // Guards against a DUT that stops mdc and would otherwise stall the bench.
  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  k;
    int  st;
    bit  ok;
    int  sv0;
    int  lc0;
    int  ae0;
    int  busy;
    time t0;
    time t1;

    reset   = 1'b1;
    en      = 1'b1;
    mdio_in = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_pins", {29'd0, mdc, mdio_out, mdio_oen}, 32'b011);
    check("rst_status", {10'd0, link_up, eth_mode, ena_10, status_valid, link_change, ack_err, phy_status}, 32'd0);

    @(negedge clk);
    #2 reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (mdio_oen === 1'b0) begin
        k = i;
        break;
      end
    end
    check("first_start_edge", k, 4);

    // Frame 1: 1000 Mb, resolved, link.
    serve_frame(16'hAC00, 1'b1, 1'b0, 1'b0);
    check("f1_outputs", {13'd0, link_up, eth_mode, ena_10, phy_status}, {13'd0, 3'b110, 16'hAC00});
    check("f1_sv_count", sv_cnt, 1);
    check("f1_lc_count", lc_cnt, 1);

    @(posedge mdc);
    t0 = $time;
    @(posedge mdc);
    t1 = $time;
    check("mdc_period", 32'(t1 - t0), 40);

    // Frame 2: 10 Mb.
    lc0 = lc_cnt;
    serve_frame(16'h0C00, 1'b1, 1'b0, 1'b1);
    check("f2_speed", {29'd0, link_up, eth_mode, ena_10}, 32'b101);
    check("f2_lc_delta", lc_cnt - lc0, 1);

    // Frame 3: same status again, no change.
    sv0 = sv_cnt;
    lc0 = lc_cnt;
    serve_frame(16'h0C00, 1'b1, 1'b0, 1'b1);
    check("f3_sv_delta", sv_cnt - sv0, 1);
    check("f3_lc_delta", lc_cnt - lc0, 0);

    // Frame 4 back to 1000 Mb, then frame 5 with the PHY absent.
    serve_frame(16'hAC00, 1'b1, 1'b0, 1'b0);
    sv0 = sv_cnt;
    lc0 = lc_cnt;
    ae0 = ae_cnt;
    serve_frame(16'h0000, 1'b0, 1'b0, 1'b0);
    check("f5_ack_err", ae_cnt - ae0, 1);
    check("f5_no_sv", sv_cnt - sv0, 0);
    check("f5_lc_delta", lc_cnt - lc0, 1);
    check("f5_outputs", {13'd0, link_up, eth_mode, ena_10, phy_status}, {13'd0, 3'b010, 16'hAC00});

    // Reserved speed code, resolved, no link.
    serve_frame(16'hC800, 1'b1, 1'b0, 1'b0);
    check("f6_outputs", {13'd0, link_up, eth_mode, ena_10, phy_status}, {13'd0, 3'b010, 16'hC800});

    // Unresolved with link bit set.
    serve_frame(16'h8400, 1'b1, 1'b0, 1'b0);
    check("f7_outputs", {13'd0, link_up, eth_mode, ena_10, phy_status}, {13'd0, 3'b010, 16'h8400});

    // en dropped mid-DATA: frame still completes.
    sv0 = sv_cnt;
    serve_frame(16'h0C00, 1'b1, 1'b1, 1'b0);
    check("f8_sv_delta", sv_cnt - sv0, 1);
    check("f8_outputs", {29'd0, link_up, eth_mode, ena_10}, 32'b101);
    busy = 0;
    repeat (2000) begin
      @(negedge clk);
      if (mdio_oen !== 1'b1) busy++;
    end
    check("no_frame_while_disabled", busy, 0);

    // Reset in the middle of the preamble while mdc is high.
    en = 1'b1;
    wait_start(st, ok);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midframe_rst_pins", {29'd0, mdc, mdio_out, mdio_oen}, 32'b011);
    check("midframe_rst_status", {13'd0, link_up, eth_mode, ena_10, phy_status}, 32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    serve_frame(16'hAC00, 1'b1, 1'b0, 1'b0);
    check("after_rst_outputs", {13'd0, link_up, eth_mode, ena_10, phy_status}, {13'd0, 3'b110, 16'hAC00});

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
